fre_disp_arbiter: RTL and testbench

Display-sharing controller in front of the six-digit 74HC595 dynamic display driver. Two requesters, channel 0 (frequency measurement) and channel 1 (status/alert messages), each offer a value, decimal-point mask and sign over a valid/ready handshake. The block grants the display round-robin with a guaranteed minimum show time per grant and a blanking gap on every owner change. It drives the driver's `data`/`point`/`sign`/`seg_en` inputs from registers.

---
 rtl/fre_disp_pkg.sv | 13 +
 rtl/fre_disp_arbiter_rr_arb2.sv | 20 ++
 rtl/fre_disp_arbiter.sv | 130 +++++++++++++
 tb/tb_fre_disp_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fre_disp_pkg.sv
// Shared types and constants for the display-sharing arbiter.
package fre_disp_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} disp_state_t;

  localparam logic [19:0] DISP_MAX = 20'd999_999;

  // Bits needed for a counter that spans 0 .. n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fre_disp_arbiter_rr_arb2.sv
// Two-way round-robin grant: when both masked requests are live, the channel
// that did not own last wins; otherwise the single live request is granted.
module rr_arb2
  import fre_disp_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] elig;

  always_comb begin
    elig  = valid & mask;
    grant = elig;
    if (elig == 2'b11) grant = last_owner ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/fre_disp_arbiter.sv
// Shares the six-digit display between two requesters with a minimum show
// time per grant and a blanking gap on every owner change.
//
//   state | meaning
//   IDLE  | display off, first valid request is shown immediately
//   BLANK | owner just changed, seg_en held low for BLANK_CNT cycles
//   SHOW  | owner displayed; non-owner may take over once hold_done
module fre_disp_arbiter
  import fre_disp_pkg::*;
#(
  parameter int HOLD_CNT  = 50_000_000,
  parameter int BLANK_CNT = 5_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        disp_off,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [19:0] req0_data,
  input  logic [19:0] req1_data,
  input  logic [5:0]  req0_point,
  input  logic [5:0]  req1_point,
  input  logic        req0_sign,
  input  logic        req1_sign,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic        owner,
  output logic        ovf
);

  localparam int HW = cnt_width(HOLD_CNT);
  localparam int BW = cnt_width(BLANK_CNT);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CNT - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CNT - 1);

  disp_state_t state, state_next;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic [BW-1:0] blank_cnt;
  logic          last_owner;
  logic [1:0]    mask, grant;
  logic          arb_last, accept, sel;
  logic [19:0]   sel_data;
  logic [5:0]    sel_point;
  logic          sel_sign;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (arb_last),
    .mask       (mask),
    .grant      (grant)
  );

  // In SHOW the owner is always eligible; the other channel only after hold.
  always_comb begin
    mask     = 2'b00;
    arb_last = last_owner;
    if (!disp_off) begin
      case (state)
        IDLE:    mask = 2'b11;
        SHOW: begin
          arb_last = owner;
          mask     = owner ? {1'b1, hold_done} : {hold_done, 1'b1};
        end
        default: mask = 2'b00;
      endcase
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign sel        = grant[1];
  assign sel_data   = sel ? req1_data  : req0_data;
  assign sel_point  = sel ? req1_point : req0_point;
  assign sel_sign   = sel ? req1_sign  : req0_sign;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHOW;
      SHOW:    if (owner ? grant[0] : grant[1]) state_next = BLANK;
      BLANK:   if (blank_cnt == '0) state_next = SHOW;
      default: state_next = IDLE;
    endcase
    if (disp_off) state_next = IDLE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      blank_cnt  <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      data       <= '0;
      point      <= '0;
      sign       <= 1'b0;
      ovf        <= 1'b0;
      seg_en     <= 1'b0;
    end else begin
      state  <= state_next;
      seg_en <= (state_next == SHOW);
      if (accept) begin
        data       <= (sel_data > DISP_MAX) ? DISP_MAX : sel_data;
        ovf        <= (sel_data > DISP_MAX);
        point      <= sel_point;
        sign       <= sel_sign;
        owner      <= sel;
        last_owner <= sel;
      end
      // Hold timer restarts on every SHOW entry; owner updates leave it alone.
      if (state_next == SHOW && state != SHOW) begin
        hold_cnt  <= HOLD_LOAD;
        hold_done <= 1'b0;
      end else if (state == SHOW) begin
        if (hold_cnt == '0) hold_done <= 1'b1;
        else hold_cnt <= hold_cnt - 1'b1;
      end
      if (state == SHOW && state_next == BLANK) blank_cnt <= BLANK_LOAD;
      else if (state == BLANK && blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fre_disp_arbiter.sv
// Directed bench for fre_disp_arbiter with a scoreboard of latched outputs.
module tb_fre_disp_arbiter;

  localparam int HOLD  = 8;
  localparam int BLANK = 3;

  logic        sys_clk = 1'b0, sys_rst = 1'b1, disp_off = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [19:0] req0_data = '0, req1_data = '0;
  logic [5:0]  req0_point = '0, req1_point = '0;
  logic        req0_sign = 1'b0, req1_sign = 1'b0;
  logic        req0_ready, req1_ready;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign, seg_en, owner, ovf;

  typedef struct packed {
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        owner;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp = '0;
  int   checks = 0, failures = 0;
  logic rdy0_s = 1'b0, rdy1_s = 1'b0;
  int   sc, n, hi, lo, rises;
  logic cur, prev_seg, exp_owner, seen_rise;

  fre_disp_arbiter #(.HOLD_CNT(HOLD), .BLANK_CNT(BLANK)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .disp_off(disp_off),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_point(req0_point), .req1_point(req1_point),
    .req0_sign(req0_sign), .req1_sign(req1_sign),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .data(data), .point(point), .sign(sign), .seg_en(seg_en),
    .owner(owner), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic ch);
    exp_t e;
    logic [19:0] d;
    d       = ch ? req1_data : req0_data;
    e.data  = (d > 20'd999999) ? 20'd999999 : d;
    e.ovf   = (d > 20'd999999);
    e.point = ch ? req1_point : req0_point;
    e.sign  = ch ? req1_sign : req0_sign;
    e.owner = ch;
    return e;
  endfunction

  // One clock: compare latched outputs at the falling edge, record transfers,
  // then return 1 time unit after the next rising edge.
  task automatic cyc();
    @(negedge sys_clk);
    if (q.size() > 0) cur_exp = q.pop_front();
    if (!sys_rst) begin
      chk("sb_data", data, cur_exp.data);
      chk("sb_point", point, cur_exp.point);
      chk("sb_sign", sign, cur_exp.sign);
      chk("sb_owner", owner, cur_exp.owner);
      chk("sb_ovf", ovf, cur_exp.ovf);
    end
    rdy0_s = req0_ready;
    rdy1_s = req1_ready;
    chk("ready_onehot", rdy0_s & rdy1_s, 0);
    if (req0_valid && rdy0_s) q.push_back(model(1'b0));
    if (req1_valid && rdy1_s) q.push_back(model(1'b1));
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_point"}, point, 0);
    chk({tag, "_sign"}, sign, 0);
    chk({tag, "_seg_en"}, seg_en, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
  endtask

  task automatic wait_show(output int cnt);
    cnt = 0;
    while (!seg_en && cnt < 20) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic grant_wait(input int ch, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget) begin
      cyc();
      if ((ch == 0 && rdy0_s) || (ch == 1 && rdy1_s)) break;
      cnt++;
    end
  endtask

  initial begin
    cyc();
    cyc();
    check_reset("rst");
    sys_rst = 1'b0;
    cyc();

    // First grant from IDLE: shown next cycle, no blank.
    req0_data = 20'd123456; req0_point = 6'b000100; req0_sign = 1'b0; req0_valid = 1'b1;
    cyc();
    chk("t1_ready0", rdy0_s, 1);
    req0_valid = 1'b0;
    chk("t1_seg_en", seg_en, 1);
    chk("t1_owner", owner, 0);
    chk("t1_data", data, 123456);
    cyc();
    chk("t1_ready_pulse", rdy0_s, 0);
    cyc();

    // Non-owner raised at SHOW cycle 2 is granted at SHOW cycle HOLD.
    req1_data = 20'd654321; req1_point = 6'b100001; req1_sign = 1'b1; req1_valid = 1'b1;
    sc = 2;
    while (sc < 30) begin
      cyc();
      if (rdy1_s) break;
      sc++;
    end
    chk("t2_grant_cycle", sc, HOLD);
    req1_valid = 1'b0;
    wait_show(n);
    chk("t2_blank_len", n, BLANK);
    chk("t2_owner", owner, 1);
    chk("t2_data", data, 654321);

    // Clamp and overflow flag, then recovery on the next owner update.
    req1_data = 20'hFFFFF; req1_point = 6'b000001; req1_sign = 1'b0; req1_valid = 1'b1;
    cyc();
    req1_data = 20'd42;
    chk("t5_clamp_data", data, 999999);
    chk("t5_ovf_set", ovf, 1);
    cyc();
    req1_valid = 1'b0;
    chk("t5_ovf_clear", ovf, 0);
    chk("t5_data", data, 42);
    chk("t5_seg_en", seg_en, 1);
    cyc();

    // Channel 0 takes over at SHOW cycle HOLD of channel 1 (now at cycle 3).
    req0_data = 20'd111111; req0_point = 6'b000000; req0_sign = 1'b0; req0_valid = 1'b1;
    grant_wait(0, 20, n);
    chk("t4_takeover_wait", n, HOLD - 3);
    req0_valid = 1'b0;
    wait_show(n);
    chk("t4_blank_len", n, BLANK);
    chk("t4_owner", owner, 0);

    // Owner update mid-hold must not move the handover.
    req1_data = 20'd777; req1_point = 6'b010000; req1_sign = 1'b0; req1_valid = 1'b1;
    req0_data = 20'd500000;
    sc = 0;
    while (sc < 30) begin
      req0_valid = (sc == 3);
      cyc();
      if (sc == 3) begin
        chk("t4_update_data", data, 500000);
        chk("t4_update_seg_en", seg_en, 1);
      end
      if (rdy1_s) break;
      sc++;
    end
    req0_valid = 1'b0;
    chk("t4_grant_cycle", sc, HOLD);

    // Both channels valid continuously: alternate owners with fixed windows.
    req0_data = 20'd1000; req0_point = 6'b000001; req1_data = 20'd2000; req1_point = 6'b000010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    prev_seg = 1'b1; seen_rise = 1'b0; lo = 0; hi = 0; rises = 0; exp_owner = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cur = seg_en;
      if (cur && !prev_seg) begin
        chk("t3_blank_len", lo, BLANK);
        chk("t3_owner_alt", owner, exp_owner);
        exp_owner = ~exp_owner;
        rises++;
        hi = 0;
      end
      if (!cur && prev_seg) begin
        if (seen_rise) chk("t3_show_len", hi, HOLD + 1);
        lo = 0;
      end
      if (cur) begin
        hi++;
        seen_rise = 1'b1;
      end else begin
        lo++;
      end
      prev_seg = cur;
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_rises", rises, 5);
    chk("t3_in_blank", seg_en, 0);
    chk("t3_final_owner", owner, exp_owner);

    // disp_off during BLANK: back to IDLE, next request shown without blank.
    disp_off = 1'b1;
    cyc();
    disp_off = 1'b0;
    chk("t6_off_seg_en", seg_en, 0);
    cyc();
    chk("t6_idle_seg_en", seg_en, 0);
    req1_data = 20'd314159; req1_point = 6'b111111; req1_sign = 1'b1; req1_valid = 1'b1;
    cyc();
    chk("t6_idle_grant", rdy1_s, 1);
    req1_valid = 1'b0;
    chk("t6_no_blank", seg_en, 1);
    chk("t6_owner", owner, 1);

    // disp_off in SHOW blocks even the owner's request.
    req1_data = 20'd5; req1_valid = 1'b1; disp_off = 1'b1;
    cyc();
    chk("t6_off_ready", rdy1_s, 0);
    chk("t6_off_show_seg", seg_en, 0);
    chk("t6_off_keep_data", data, 314159);
    disp_off = 1'b0; req1_valid = 1'b0;
    cyc();
    req0_data = 20'd271828; req0_point = 6'b000010; req0_sign = 1'b0; req0_valid = 1'b1;
    cyc();
    req0_valid = 1'b0;
    chk("t6_reshow_seg", seg_en, 1);
    chk("t6_reshow_owner", owner, 0);
    cyc();
    cyc();

    // Asynchronous reset mid-SHOW.
    sys_rst = 1'b1;
    #1;
    check_reset("rst_mid");
    q.delete();
    cur_exp = '0;
    cyc();
    sys_rst = 1'b0;
    cyc();

    // last_owner resets to 1, so channel 0 wins a tie from IDLE.
    req0_data = 20'd42424; req0_point = 6'b000000; req0_sign = 1'b0;
    req1_data = 20'd99;    req1_point = 6'b000000; req1_sign = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cyc();
    chk("t7_tie_ready0", rdy0_s, 1);
    chk("t7_tie_ready1", rdy1_s, 0);
    req0_valid = 1'b0;

    // Channel 1 withdraws before hold completes: nothing transfers.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t7_early_ready1", rdy1_s, 0);
    end
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("t7_owner_kept", owner, 0);
    chk("t7_data_kept", data, 42424);
    chk("t7_seg_en", seg_en, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
